// File: rtl/model_fetch_pkg.sv
// model_fetch_pkg
//   Shared types for the model fetch sequencer.
//   mfs_state_t : sequencer FSM states.
//   mfs_beat_t  : tag part of an output-buffer entry. A buffer entry is
//                 {mfs_beat_t, payload}, and the payload is VERTEX_DATA_WIDTH
//                 bits wide. The payload is kept out of the struct so that the
//                 data width stays a module parameter.
package model_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_VERT  = 3'd2,
        ST_IDX   = 3'd3,
        ST_DRAIN = 3'd4
    } mfs_state_t;

    typedef struct packed {
        logic is_index;   // 0 = vertex word, 1 = face/index word
        logic last;       // final word of its buffer
    } mfs_beat_t;

    localparam int MFS_TAG_W = $bits(mfs_beat_t);

endpackage

// File: rtl/mfs_beat_fifo.sv
// mfs_beat_fifo
//   Synchronous FIFO of registered entries. The head entry is read straight
//   out of the storage registers, so rd_data only changes on a clock edge.
//   A write into a full FIFO is accepted only when a read happens in the same
//   cycle. A read from an empty FIFO is ignored.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset (flushes the FIFO)
//   wr_en, wr_data     push side
//   rd_en              pop request; a pop takes effect only when rd_valid is high
//   rd_data, rd_valid  head entry and its valid flag
//   count              number of stored entries
module mfs_beat_fifo #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign rd_ok    = rd_en && (count != '0);
    assign wr_ok    = wr_en && ((count != CW'(DEPTH)) || rd_ok);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/model_fetch_sequencer.sv
// model_fetch_sequencer
//   Drives one model_reader per draw request. The sequencer restarts the reader
//   for the requested model and then streams the vertex buffer followed by the
//   index buffer into one output beat stream with valid/ready backpressure.
//
// Handshakes: a transfer happens on a clock edge where valid && ready are both
//   high. Once valid is asserted, it and its payload stay unchanged until that
//   transfer.
//
// Optional feature: define MODEL_FETCH_SEQ_PERF_EN to add perf_stall_cycles.
//   This is a saturating 32-bit count of out_valid && !out_ready cycles. It
//   clears when a request is accepted.
//
// Ports:
//   clk, rstn                        clock, asynchronous active-low reset
//   req_valid/req_ready              draw request handshake
//   req_model_index                  model to fetch
//   rd_rstn, rd_model_index          reader reset and model select
//   rd_ready                         reader header loaded
//   rd_vertex_read_en/rd_index_read_en   reader read strobes (never both high)
//   rd_vertex_data/_dv/_last         reader vertex port
//   rd_index_data/_dv/_last          reader index port
//   out_valid/out_ready/out_data     output beat stream (index words zero-extended)
//   out_is_index, out_last           beat tags
//   done                             one-cycle pulse after the model fully drains
//   busy                             high whenever not IDLE
module model_fetch_sequencer
    import model_fetch_pkg::*;
#(
    parameter int MODEL_INDEX_WIDTH = 4,
    parameter int VERTEX_DATA_WIDTH = 72,
    parameter int INDEX_DATA_WIDTH  = 36,
    parameter int FIFO_DEPTH        = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [MODEL_INDEX_WIDTH-1:0] req_model_index,
    output logic                         rd_rstn,
    output logic [MODEL_INDEX_WIDTH-1:0] rd_model_index,
    input  logic                         rd_ready,
    output logic                         rd_vertex_read_en,
    output logic                         rd_index_read_en,
    input  logic [VERTEX_DATA_WIDTH-1:0] rd_vertex_data,
    input  logic                         rd_vertex_dv,
    input  logic                         rd_vertex_last,
    input  logic [INDEX_DATA_WIDTH-1:0]  rd_index_data,
    input  logic                         rd_index_dv,
    input  logic                         rd_index_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [VERTEX_DATA_WIDTH-1:0] out_data,
    output logic                         out_is_index,
    output logic                         out_last,
    output logic                         done,
    output logic                         busy
`ifdef MODEL_FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]                  perf_stall_cycles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = MFS_TAG_W + VERTEX_DATA_WIDTH;

    mfs_state_t state;
    mfs_state_t state_nxt;

    logic [MODEL_INDEX_WIDTH-1:0] model_idx_q;
    logic                         inflight_q;
    logic                         inflight_last_q;
    logic                         issue_last;
    logic                         pop;
    logic                         room;
    logic [CW:0]                  occupancy;
    logic [CW-1:0]                fifo_count;
    logic                         fifo_wr;
    mfs_beat_t                    wr_tag;
    mfs_beat_t                    rd_tag;
    logic [VERTEX_DATA_WIDTH-1:0] wr_payload;
    logic [EW-1:0]                fifo_wr_data;
    logic [EW-1:0]                fifo_rd_data;
    logic                         accept;

    assign req_ready      = (state == ST_IDLE) && rstn;
    assign accept         = req_valid && req_ready;
    assign busy           = (state != ST_IDLE);
    assign rd_rstn        = (state != ST_IDLE);
    assign rd_model_index = model_idx_q;

    // The entry whose dv arrives this cycle is still counted as inflight.
    // This makes the room check conservative by one cycle. It can never
    // overflow the buffer, and it still allows one issue per cycle when the
    // consumer pops every cycle.
    assign pop       = out_valid && out_ready;
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign room      = (occupancy < (CW+1)'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        rd_vertex_read_en = 1'b0;
        rd_index_read_en  = 1'b0;
        issue_last        = 1'b0;
        done              = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = ST_LOAD;
                end
            end
            // The first vertex read goes out in the same cycle that the reader
            // reports ready. This saves a cycle of request-to-data latency.
            ST_LOAD: begin
                if (rd_ready) begin
                    if (room) begin
                        rd_vertex_read_en = 1'b1;
                        issue_last        = rd_vertex_last;
                        state_nxt         = rd_vertex_last ? ST_IDX : ST_VERT;
                    end else begin
                        state_nxt = ST_VERT;
                    end
                end
            end
            ST_VERT: begin
                if (room) begin
                    rd_vertex_read_en = 1'b1;
                    issue_last        = rd_vertex_last;
                    if (rd_vertex_last) begin
                        state_nxt = ST_IDX;
                    end
                end
            end
            ST_IDX: begin
                if (room) begin
                    rd_index_read_en = 1'b1;
                    issue_last       = rd_index_last;
                    if (rd_index_last) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((fifo_count == '0) && !inflight_q) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The last flag is captured when the read is issued and travels with the
    // outstanding read. The dv returned one cycle later then carries it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_idx_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (accept) begin
                model_idx_q <= req_model_index;
            end
            if (rd_vertex_read_en || rd_index_read_en) begin
                inflight_q      <= 1'b1;
                inflight_last_q <= issue_last;
            end else if (rd_vertex_dv || rd_index_dv) begin
                inflight_q <= 1'b0;
            end
        end
    end

    assign fifo_wr         = rd_vertex_dv || rd_index_dv;
    assign wr_tag.is_index = rd_index_dv;
    assign wr_tag.last     = inflight_last_q;
    assign wr_payload      = rd_index_dv ? VERTEX_DATA_WIDTH'(rd_index_data) : rd_vertex_data;
    assign fifo_wr_data    = {wr_tag, wr_payload};

    mfs_beat_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (fifo_wr),
        .wr_data  (fifo_wr_data),
        .rd_en    (out_ready),
        .rd_data  (fifo_rd_data),
        .rd_valid (out_valid),
        .count    (fifo_count)
    );

    assign rd_tag       = fifo_rd_data[EW-1:VERTEX_DATA_WIDTH];
    assign out_data     = fifo_rd_data[VERTEX_DATA_WIDTH-1:0];
    assign out_is_index = rd_tag.is_index;
    assign out_last     = rd_tag.last;

`ifdef MODEL_FETCH_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_stall_cycles <= '0;
        end else if (accept) begin
            perf_stall_cycles <= '0;
        end else if (out_valid && !out_ready && (perf_stall_cycles != '1)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_model_fetch_sequencer.sv
// tb_model_fetch_sequencer
//   Bench for model_fetch_sequencer. It contains a behavioural model_reader:
//   ready comes 4 cycles after the reader is released, and dv follows a read
//   enable by one cycle. When a request is accepted, the bench queues every
//   beat expected from that model. A negedge monitor pops the queue and
//   compares whenever a beat is transferred. The monitor also checks
//   hold-under-stall, read-issue rules and done pulses.
//   The perf counter test runs when MODEL_FETCH_SEQ_PERF_EN is defined.
module tb_model_fetch_sequencer;

    localparam int MIW = 4;
    localparam int VW  = 72;
    localparam int IW  = 36;
    localparam int EW  = VW + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic           req_valid;
    logic           req_ready;
    logic [MIW-1:0] req_model_index;
    logic           rd_rstn;
    logic [MIW-1:0] rd_model_index;
    logic           rd_ready;
    logic           rd_vertex_read_en;
    logic           rd_index_read_en;
    logic [VW-1:0]  rd_vertex_data = '0;
    logic           rd_vertex_dv   = 1'b0;
    logic           rd_vertex_last;
    logic [IW-1:0]  rd_index_data  = '0;
    logic           rd_index_dv    = 1'b0;
    logic           rd_index_last;
    logic           out_valid;
    logic           out_ready;
    logic [VW-1:0]  out_data;
    logic           out_is_index;
    logic           out_last;
    logic           done;
    logic           busy;
`ifdef MODEL_FETCH_SEQ_PERF_EN
    logic [31:0]    perf_stall_cycles;
`endif

    model_fetch_sequencer #(
        .MODEL_INDEX_WIDTH (MIW),
        .VERTEX_DATA_WIDTH (VW),
        .INDEX_DATA_WIDTH  (IW),
        .FIFO_DEPTH        (2)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_model_index   (req_model_index),
        .rd_rstn           (rd_rstn),
        .rd_model_index    (rd_model_index),
        .rd_ready          (rd_ready),
        .rd_vertex_read_en (rd_vertex_read_en),
        .rd_index_read_en  (rd_index_read_en),
        .rd_vertex_data    (rd_vertex_data),
        .rd_vertex_dv      (rd_vertex_dv),
        .rd_vertex_last    (rd_vertex_last),
        .rd_index_data     (rd_index_data),
        .rd_index_dv       (rd_index_dv),
        .rd_index_last     (rd_index_last),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_is_index      (out_is_index),
        .out_last          (out_last),
        .done              (done),
        .busy              (busy)
`ifdef MODEL_FETCH_SEQ_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // ---------------- model table and word formats ----------------
    function automatic int n_verts(input logic [MIW-1:0] mi);
        case (mi)
            4'd3:    return 3;
            4'd5:    return 1;
            4'd9:    return 6;
            4'd7:    return 2;
            4'd1:    return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int n_faces(input logic [MIW-1:0] mi);
        case (mi)
            4'd3:    return 2;
            4'd5:    return 1;
            4'd9:    return 2;
            4'd7:    return 4;
            4'd1:    return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [VW-1:0] vert_word(input logic [MIW-1:0] mi, input int k);
        return {24'(mi), 24'(k), 24'h5A5A5A};
    endfunction

    function automatic logic [IW-1:0] idx_word(input logic [MIW-1:0] mi, input int k);
        return {12'(mi), 12'(k), 12'hC3C};
    endfunction

    // ---------------- behavioural model_reader ----------------
    logic [3:0] r_cnt  = '0;
    int         r_vptr = 0;
    int         r_iptr = 0;

    assign rd_ready       = (r_cnt == 4'd4);
    assign rd_vertex_last = (r_vptr == n_verts(rd_model_index) - 1);
    assign rd_index_last  = (r_iptr == n_faces(rd_model_index) - 1);

    always @(posedge clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            r_cnt          <= '0;
            r_vptr         <= 0;
            r_iptr         <= 0;
            rd_vertex_dv   <= 1'b0;
            rd_index_dv    <= 1'b0;
            rd_vertex_data <= '0;
            rd_index_data  <= '0;
        end else begin
            if (r_cnt != 4'd4) r_cnt <= r_cnt + 4'd1;
            rd_vertex_dv <= rd_vertex_read_en;
            rd_index_dv  <= rd_index_read_en;
            if (rd_vertex_read_en) begin
                rd_vertex_data <= vert_word(rd_model_index, r_vptr);
                r_vptr         <= r_vptr + 1;
            end
            if (rd_index_read_en) begin
                rd_index_data <= idx_word(rd_model_index, r_iptr);
                r_iptr        <= r_iptr + 1;
            end
        end
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            beat_cyc[$];
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    int            exp_done = 0;
    int            last_done_cyc = -1;
    int            pops = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_model(input logic [MIW-1:0] mi);
        int nv;
        int nf;
        nv = n_verts(mi);
        nf = n_faces(mi);
        for (int k = 0; k < nv; k++) exp_q.push_back({1'b0, (k == nv - 1), vert_word(mi, k)});
        for (int k = 0; k < nf; k++) exp_q.push_back({1'b1, (k == nf - 1), VW'(idx_word(mi, k))});
    endtask

    // ---------------- monitor ----------------
    logic          stall_q = 1'b0;
    logic [EW-1:0] held = '0;
    int            stored = 0;

    always @(negedge clk) begin
        logic          pop_now;
        logic [EW-1:0] act;
        int            dv_now;
        if (!rstn) begin
            stall_q = 1'b0;
            stored  = 0;
        end else begin
            act     = {out_is_index, out_last, out_data};
            pop_now = out_valid && out_ready;
            dv_now  = (rd_vertex_dv || rd_index_dv) ? 1 : 0;
            if (stall_q) begin
                chk("hold_valid", 80'(out_valid), 80'(1));
                chk("hold_beat", 80'(act), 80'(held));
            end
            if (pop_now) begin
                pops++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none (cycle %0d)", act, cyc);
                end else begin
                    chk("beat", 80'(act), 80'(exp_q.pop_front()));
                end
            end
            stall_q = out_valid && !out_ready;
            held    = act;
            if (rd_vertex_read_en || rd_index_read_en) begin
                chk("one_read_en", 80'(rd_vertex_read_en && rd_index_read_en), 80'(0));
                chk("read_room", 80'((stored + dv_now - (pop_now ? 1 : 0)) <= 1), 80'(1));
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            stored = stored + dv_now - (pop_now ? 1 : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [MIW-1:0] mi, output int t_acc);
        int n;
        n = 0;
        req_model_index = mi;
        req_valid       = 1'b1;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        chk("req_accepted", 80'(req_ready), 80'(1));
        t_acc = cyc;
        push_model(mi);
        exp_done++;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt < exp_done && n < 300) begin
            step();
            n++;
        end
        chk("done_count", 80'(done_cnt), 80'(exp_done));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int n;
        int base;
        rstn            = 1'b0;
        req_valid       = 1'b0;
        req_model_index = '0;
        out_ready       = 1'b1;
        step();
        step();
        // reset values
        chk("rst_req_ready", 80'(req_ready), 80'(0));
        chk("rst_rd_rstn", 80'(rd_rstn), 80'(0));
        chk("rst_rd_model_index", 80'(rd_model_index), 80'(0));
        chk("rst_read_en", 80'({rd_vertex_read_en, rd_index_read_en}), 80'(0));
        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_out_tags", 80'({out_data, out_is_index, out_last}), 80'(0));
        chk("rst_done_busy", 80'({done, busy}), 80'(0));
        rstn = 1'b1;
        step();
        chk("idle_req_ready", 80'(req_ready), 80'(1));

        // 1: 3 vertices, 2 faces, no backpressure, exact latency
        beat_cyc.delete();
        issue_req(4'd3, t);
        wait_done();
        chk("t1_beats", 80'(beat_cyc.size()), 80'(5));
        for (int i = 0; i < 5 && i < beat_cyc.size(); i++) begin
            chk("t1_beat_cycle", 80'(beat_cyc[i]), 80'(t + 7 + i));
        end
        chk("t1_done_cycle", 80'(last_done_cyc), 80'(t + 12));

        // 2: same model, out_ready low for 3 cycles after V1
        base = pops;
        issue_req(4'd3, t);
        n = 0;
        while (pops < base + 2 && n < 50) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        wait_done();

        // 3: one vertex, one face
        issue_req(4'd5, t);
        wait_done();

        // 4: request pulsed during VERT is ignored, a held request follows
        issue_req(4'd9, t);
        n = 0;
        while (!rd_vertex_read_en && n < 20) begin
            step();
            n++;
        end
        step();
        req_model_index = 4'd1;
        req_valid       = 1'b1;
        chk("busy_req_ready", 80'(req_ready), 80'(0));
        chk("busy_flag", 80'(busy), 80'(1));
        step();
        req_valid = 1'b0;
        step();
        issue_req(4'd5, t);
        wait_done();

        // 5: asynchronous reset during IDX, then a fresh request
        issue_req(4'd7, t);
        n = 0;
        while (!rd_index_read_en && n < 20) begin
            step();
            n++;
        end
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 80'(out_valid), 80'(0));
        chk("mid_rst_busy", 80'(busy), 80'(0));
        chk("mid_rst_read_en", 80'({rd_vertex_read_en, rd_index_read_en}), 80'(0));
        chk("mid_rst_rd_rstn", 80'(rd_rstn), 80'(0));
        exp_q.delete();
        exp_done--;
        step();
        step();
        rstn = 1'b1;
        step();
        issue_req(4'd3, t);
        wait_done();

`ifdef MODEL_FETCH_SEQ_PERF_EN
        // 6: four stalled cycles, then a new request clears the count
        issue_req(4'd3, t);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        wait_done();
        chk("perf_stall_4", 80'(perf_stall_cycles), 80'(4));
        issue_req(4'd5, t);
        chk("perf_cleared", 80'(perf_stall_cycles), 80'(0));
        wait_done();
`endif

        repeat (5) step();
        chk("exp_q_drained", 80'(exp_q.size()), 80'(0));
        chk("final_done_count", 80'(done_cnt), 80'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
